id_stage_ctrl: RTL and testbench

- Decode-side partner of the fetch unit in the 5-stage MIPS pipeline.
- Captures the fetched instruction and PC+4 into the IF/ID register and decodes branch/jump type.
- Resolves beq compare in D and drives the fetch unit's control inputs: nPC_sel, cmp, im26, MFRSD, disable_PC.
- Detects load-use and branch-dependence hazards, then stalls fetch and bubbles E.

---
 rtl/mips_defs.sv | 24 ++
 rtl/id_hazard_detect.sv | 50 +++++
 rtl/id_stage_ctrl.sv | 102 ++++++++++
 tb/tb_id_stage_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Opcode/funct constants and next-PC select encodings shared by the
// decode-stage control blocks.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

endpackage

// File: rtl/id_hazard_detect.sv
// Load-use and branch/jump-register dependence detection for the D stage.
// Optional macro ID_STAGE_CTRL_BNE_EN treats bne like beq.
module id_hazard_detect
    import mips_defs::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic [4:0] E_wr_reg,
    input  logic       E_reg_write,
    input  logic       E_is_load,
    input  logic [4:0] M_wr_reg,
    input  logic       M_is_load,
    output logic       stall
);

    logic is_br;
    logic is_jr;
    logic uses_rs;
    logic uses_rt;
    logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;
    logic load_use, br_e, br_m, jr_e, jr_m;

    always_comb begin
`ifdef ID_STAGE_CTRL_BNE_EN
        is_br = (op == OP_BEQ) || (op == OP_BNE);
`else
        is_br = (op == OP_BEQ);
`endif
        is_jr   = (op == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR));
        uses_rs = !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI));
        uses_rt = (op == OP_RTYPE) || (op == OP_SW) || is_br;
    end

    // $0 is hardwired, so a write to it never creates a dependence
    assign e_hit_rs = (E_wr_reg != 5'd0) && (E_wr_reg == rs);
    assign e_hit_rt = (E_wr_reg != 5'd0) && (E_wr_reg == rt);
    assign m_hit_rs = (M_wr_reg != 5'd0) && (M_wr_reg == rs);
    assign m_hit_rt = (M_wr_reg != 5'd0) && (M_wr_reg == rt);

    assign load_use = E_is_load && ((uses_rs && e_hit_rs) || (uses_rt && e_hit_rt));
    assign br_e     = is_br && E_reg_write && (e_hit_rs || e_hit_rt);
    assign br_m     = is_br && M_is_load && (m_hit_rs || m_hit_rt);
    assign jr_e     = is_jr && E_reg_write && e_hit_rs;
    assign jr_m     = is_jr && M_is_load && m_hit_rs;

    assign stall = load_use || br_e || br_m || jr_e || jr_m;

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage control: IF/ID register, branch/jump decode, beq compare,
// and stall generation. Optional macro ID_STAGE_CTRL_BNE_EN adds bne.
module id_stage_ctrl
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC_ADD_4 = 32'h0000_3004,
    parameter int          STALL_CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            F_instr,
    input  logic [31:0]            F_pc_add_4,
    input  logic [31:0]            rs_fwd,
    input  logic [31:0]            rt_fwd,
    input  logic [4:0]             E_wr_reg,
    input  logic                   E_reg_write,
    input  logic                   E_is_load,
    input  logic [4:0]             M_wr_reg,
    input  logic                   M_is_load,
    output logic [31:0]            D_instr,
    output logic [31:0]            D_pc_add_4,
    output logic [1:0]             nPC_sel,
    output logic                   cmp,
    output logic [25:0]            im26,
    output logic [31:0]            MFRSD,
    output logic                   disable_PC,
    output logic                   E_flush,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic       stall;
    logic [5:0] op;
    logic [5:0] funct;
    logic       regs_eq;
    npc_sel_e   npc;

    assign op      = D_instr[31:26];
    assign funct   = D_instr[5:0];
    assign regs_eq = (rs_fwd == rt_fwd);

    id_hazard_detect u_hazard (
        .op          (op),
        .funct       (funct),
        .rs          (D_instr[25:21]),
        .rt          (D_instr[20:16]),
        .E_wr_reg    (E_wr_reg),
        .E_reg_write (E_reg_write),
        .E_is_load   (E_is_load),
        .M_wr_reg    (M_wr_reg),
        .M_is_load   (M_is_load),
        .stall       (stall)
    );

    // No flush on redirect: the delay-slot instruction is captured normally
    always_ff @(posedge clk) begin
        if (reset) begin
            D_instr    <= 32'd0;
            D_pc_add_4 <= RESET_PC_ADD_4;
        end else if (!stall) begin
            D_instr    <= F_instr;
            D_pc_add_4 <= F_pc_add_4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        npc = NPC_SEQ;
        cmp = 1'b0;
        case (op)
            OP_BEQ: begin
                npc = NPC_BR;
                cmp = regs_eq;
            end
`ifdef ID_STAGE_CTRL_BNE_EN
            OP_BNE: begin
                npc = NPC_BR;
                cmp = !regs_eq;
            end
`endif
            OP_J, OP_JAL: npc = NPC_J;
            OP_RTYPE: begin
                if ((funct == FN_JR) || (funct == FN_JALR))
                    npc = NPC_JR;
            end
            default: npc = NPC_SEQ;
        endcase
    end

    assign nPC_sel    = npc;
    assign im26       = D_instr[25:0];
    assign MFRSD      = rs_fwd;
    assign disable_PC = stall;
    assign E_flush    = stall;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Self-checking bench for id_stage_ctrl: directed scenarios plus randomized
// traffic against a behavioural model of the decode/hazard rules.
module tb_id_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] F_instr = '0, F_pc_add_4 = '0, rs_fwd = '0, rt_fwd = '0;
    logic [4:0]  E_wr_reg = '0, M_wr_reg = '0;
    logic        E_reg_write = 1'b0, E_is_load = 1'b0, M_is_load = 1'b0;
    logic [31:0] D_instr, D_pc_add_4, MFRSD;
    logic [1:0]  nPC_sel;
    logic        cmp, disable_PC, E_flush;
    logic [25:0] im26;
    logic [31:0] stall_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] m_d_instr, m_d_pc, m_cnt;

    id_stage_ctrl dut (
        .clk(clk), .reset(reset), .F_instr(F_instr), .F_pc_add_4(F_pc_add_4),
        .rs_fwd(rs_fwd), .rt_fwd(rt_fwd), .E_wr_reg(E_wr_reg),
        .E_reg_write(E_reg_write), .E_is_load(E_is_load), .M_wr_reg(M_wr_reg),
        .M_is_load(M_is_load), .D_instr(D_instr), .D_pc_add_4(D_pc_add_4),
        .nPC_sel(nPC_sel), .cmp(cmp), .im26(im26), .MFRSD(MFRSD),
        .disable_PC(disable_PC), .E_flush(E_flush), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

`ifdef ID_STAGE_CTRL_BNE_EN
    localparam bit BNE_ON = 1'b1;
`else
    localparam bit BNE_ON = 1'b0;
`endif

    // Reference: classify the instruction by name, then derive behaviour.
    function automatic string m_kind(logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        logic [5:0] fn = ins[5:0];
        if (op == 6'd4) return "beq";
        if (op == 6'd5) return BNE_ON ? "bne" : "other";
        if (op == 6'd2 || op == 6'd3) return "jump";
        if (op == 6'd15) return "lui";
        if (op == 6'd0 && (fn == 6'd8 || fn == 6'd9)) return "jr";
        if (op == 6'd0) return "rtype";
        if (op == 6'h2B) return "sw";
        return "other";
    endfunction

    function automatic logic [1:0] m_npc(logic [31:0] ins);
        string k = m_kind(ins);
        if (k == "beq" || k == "bne") return 2'd1;
        if (k == "jump") return 2'd2;
        if (k == "jr") return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic m_cmp(logic [31:0] ins, logic [31:0] a, logic [31:0] b);
        string k = m_kind(ins);
        if (k == "beq") return a == b;
        if (k == "bne") return a != b;
        return 1'b0;
    endfunction

    function automatic logic m_stall(logic [31:0] ins, logic ew, logic el, logic [4:0] er,
                                     logic ml, logic [4:0] mr);
        string k = m_kind(ins);
        logic [4:0] srcs[$];
        logic [4:0] dsrcs[$];
        logic s = 1'b0;
        if (!(k == "jump" || k == "lui")) srcs.push_back(ins[25:21]);
        if (k == "rtype" || k == "jr" || k == "beq" || k == "bne" || k == "sw")
            srcs.push_back(ins[20:16]);
        if (k == "beq" || k == "bne") dsrcs = srcs;
        if (k == "jr") dsrcs.push_back(ins[25:21]);
        foreach (srcs[i])
            if (srcs[i] != 0 && el && srcs[i] == er) s = 1'b1;
        foreach (dsrcs[i]) begin
            if (dsrcs[i] != 0 && ew && dsrcs[i] == er) s = 1'b1;
            if (dsrcs[i] != 0 && ml && dsrcs[i] == mr) s = 1'b1;
        end
        return s;
    endfunction

    task automatic tick();
        logic st = m_stall(m_d_instr, E_reg_write, E_is_load, E_wr_reg, M_is_load, M_wr_reg);
        @(posedge clk);
        if (reset) begin
            m_d_instr = 32'd0; m_d_pc = 32'h0000_3004; m_cnt = 32'd0;
        end else begin
            if (!st) begin m_d_instr = F_instr; m_d_pc = F_pc_add_4; end
            else if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic clear_hz();
        E_reg_write = 0; E_is_load = 0; E_wr_reg = 0; M_is_load = 0; M_wr_reg = 0;
    endtask

    task automatic load_d(logic [31:0] ins, logic [31:0] pc);
        clear_hz();
        reset = 0; F_instr = ins; F_pc_add_4 = pc;
        tick();
    endtask

    task automatic test_reset();
        reset = 1; F_instr = 32'hFFFF_FFFF; F_pc_add_4 = 32'h1234_5678;
        tick();
        tests_run += 5;
        if (D_instr !== 32'd0) begin tests_failed++; $display("FAIL reset_instr got %h want 0", D_instr); end
        if (D_pc_add_4 !== 32'h3004) begin tests_failed++; $display("FAIL reset_pc got %h want 3004", D_pc_add_4); end
        if (disable_PC !== 1'b0) begin tests_failed++; $display("FAIL reset_dis got %b want 0", disable_PC); end
        if (stall_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
        if (nPC_sel !== 2'b00 || E_flush !== 1'b0 || cmp !== 1'b0) begin
            tests_failed++; $display("FAIL reset_decode got npc=%b flush=%b cmp=%b want 00/0/0", nPC_sel, E_flush, cmp);
        end
        reset = 0;
    endtask

    task automatic test_beq_taken();
        load_d(32'h1085_0003, 32'h0000_0100);
        rs_fwd = 7; rt_fwd = 7; F_instr = 32'h2402_00AA; F_pc_add_4 = 32'h104;
        #1;
        tests_run += 2;
        if (nPC_sel !== 2'b01 || cmp !== 1'b1 || disable_PC !== 1'b0) begin
            tests_failed++; $display("FAIL beq_taken got npc=%b cmp=%b dis=%b want 01/1/0", nPC_sel, cmp, disable_PC);
        end
        tick();
        if (D_instr !== 32'h2402_00AA || D_pc_add_4 !== 32'h104) begin
            tests_failed++; $display("FAIL beq_delay_slot got %h/%h want 240200aa/104", D_instr, D_pc_add_4);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] c0;
        load_d(32'h0085_1821, 32'h200);
        c0 = stall_cnt;
        E_is_load = 1; E_reg_write = 1; E_wr_reg = 5; F_instr = 32'hDEAD_0000; F_pc_add_4 = 32'h204;
        #1;
        tests_run += 3;
        if (disable_PC !== 1'b1 || E_flush !== 1'b1) begin
            tests_failed++; $display("FAIL load_use_stall got dis=%b flush=%b want 1/1", disable_PC, E_flush);
        end
        tick();
        if (D_instr !== 32'h0085_1821 || stall_cnt !== c0 + 1) begin
            tests_failed++; $display("FAIL load_use_hold got %h cnt=%0d want 00851821 cnt=%0d", D_instr, stall_cnt, c0 + 1);
        end
        clear_hz(); #1;
        tick();
        if (D_instr !== 32'hDEAD_0000) begin
            tests_failed++; $display("FAIL load_use_release got %h want dead0000", D_instr);
        end
    endtask

    task automatic test_jr_after_lw();
        logic [31:0] c0;
        load_d(32'h03E0_0008, 32'h300);
        c0 = stall_cnt;
        rs_fwd = 32'h0000_4A5C; F_instr = 32'h0000_0000;
        E_is_load = 1; E_reg_write = 1; E_wr_reg = 31; #1;
        tests_run += 4;
        if (disable_PC !== 1'b1) begin tests_failed++; $display("FAIL jr_stall1 got %b want 1", disable_PC); end
        tick();
        clear_hz(); M_is_load = 1; M_wr_reg = 31; #1;
        if (disable_PC !== 1'b1) begin tests_failed++; $display("FAIL jr_stall2 got %b want 1", disable_PC); end
        tick();
        clear_hz(); #1;
        if (disable_PC !== 1'b0 || nPC_sel !== 2'b11 || MFRSD !== 32'h0000_4A5C) begin
            tests_failed++; $display("FAIL jr_redirect got dis=%b npc=%b tgt=%h want 0/11/00004a5c", disable_PC, nPC_sel, MFRSD);
        end
        if (stall_cnt !== c0 + 2) begin
            tests_failed++; $display("FAIL jr_cnt got %0d want %0d", stall_cnt, c0 + 2);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        load_d(32'h1000_0000, 32'h400);
        E_reg_write = 1; E_is_load = 1; E_wr_reg = 0; M_is_load = 1; M_wr_reg = 0;
        rs_fwd = 5; rt_fwd = 5; #1;
        tests_run += 1;
        if (disable_PC !== 1'b0 || cmp !== 1'b1) begin
            tests_failed++; $display("FAIL zero_reg got dis=%b cmp=%b want 0/1", disable_PC, cmp);
        end
        clear_hz();
    endtask

    task automatic test_bne();
        load_d(32'h1485_0002, 32'h500);
        rs_fwd = 1; rt_fwd = 2; #1;
        tests_run += 1;
        if (nPC_sel !== (BNE_ON ? 2'b01 : 2'b00) || cmp !== BNE_ON) begin
            tests_failed++; $display("FAIL bne got npc=%b cmp=%b want %b/%b", nPC_sel, cmp, BNE_ON ? 2'b01 : 2'b00, BNE_ON);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rs = 5'($urandom_range(0, 7));
        logic [4:0] rt = 5'($urandom_range(0, 7));
        logic [15:0] lo = 16'($urandom);
        case ($urandom_range(0, 10))
            0: return {6'h04, rs, rt, lo};
            1: return {6'h05, rs, rt, lo};
            2: return {6'h02, 26'($urandom)};
            3: return {6'h03, 26'($urandom)};
            4: return {6'h23, rs, rt, lo};
            5: return {6'h2B, rs, rt, lo};
            6: return {6'h0F, rs, rt, lo};
            7: return {6'h00, rs, 15'd0, 6'h08};
            8: return {6'h00, rs, rt, 5'd31, 5'd0, 6'h09};
            9: return {6'h00, rs, rt, lo[15:6], 6'h21};
            default: return {6'h0D, rs, rt, lo};
        endcase
    endfunction

    task automatic test_random();
        logic st;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            F_instr = rand_instr(); F_pc_add_4 = $urandom;
            rs_fwd = 32'($urandom_range(0, 3)); rt_fwd = 32'($urandom_range(0, 3));
            E_wr_reg = 5'($urandom_range(0, 7)); M_wr_reg = 5'($urandom_range(0, 7));
            E_is_load = ($urandom_range(0, 2) == 0);
            E_reg_write = E_is_load | ($urandom_range(0, 1) == 1);
            M_is_load = ($urandom_range(0, 2) == 0);
            #1;
            st = m_stall(m_d_instr, E_reg_write, E_is_load, E_wr_reg, M_is_load, M_wr_reg);
            tests_run += 2;
            if (nPC_sel !== m_npc(m_d_instr) || cmp !== m_cmp(m_d_instr, rs_fwd, rt_fwd) ||
                disable_PC !== st || E_flush !== st || im26 !== m_d_instr[25:0] || MFRSD !== rs_fwd) begin
                tests_failed++;
                $display("FAIL rand_comb i=%0d ins=%h got npc=%b cmp=%b dis=%b fl=%b want npc=%b cmp=%b stall=%b",
                         i, m_d_instr, nPC_sel, cmp, disable_PC, E_flush, m_npc(m_d_instr),
                         m_cmp(m_d_instr, rs_fwd, rt_fwd), st);
            end
            tick();
            if (D_instr !== m_d_instr || D_pc_add_4 !== m_d_pc || stall_cnt !== m_cnt) begin
                tests_failed++;
                $display("FAIL rand_regs i=%0d got %h/%h/%0d want %h/%h/%0d",
                         i, D_instr, D_pc_add_4, stall_cnt, m_d_instr, m_d_pc, m_cnt);
            end
        end
        reset = 0;
    endtask

    initial begin
        m_d_instr = 0; m_d_pc = 32'h3004; m_cnt = 0;
        test_reset();
        test_beq_taken();
        test_load_use();
        test_jr_after_lw();
        test_zero_reg();
        test_bne();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
